// File: rtl/preamble_serializer.sv
// Bit-serial frame transmitter: sends a fixed sync preamble MSB-first, then the captured
// payload MSB-first, then returns the line to idle and pulses done for one cycle.
module preamble_serializer #(
    parameter int unsigned          PRE_W    = 8,
    parameter logic [PRE_W-1:0]     PREAMBLE = 8'b1010_1010,
    parameter int unsigned          DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              dout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned MaxW = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int unsigned CntW = (MaxW > 1) ? $clog2(MaxW) : 1;

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StPre  = 3'b010,
        StData = 3'b100
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [DATA_W-1:0]   pay_q, pay_d;
    logic                dout_q, dout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pre_q   <= '0;
            pay_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            pay_q   <= pay_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        pay_d   = pay_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                dout_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    // First preamble bit goes out now; the shifter holds the remainder.
                    pay_d   = data;
                    pre_d   = PREAMBLE << 1;
                    dout_d  = PREAMBLE[PRE_W-1];
                    busy_d  = 1'b1;
                    cnt_d   = CntW'(PRE_W - 1);
                    state_d = StPre;
                end
            end
            StPre: begin
                if (cnt_q != '0) begin
                    dout_d = pre_q[PRE_W-1];
                    pre_d  = pre_q << 1;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    dout_d  = pay_q[DATA_W-1];
                    pay_d   = pay_q << 1;
                    cnt_d   = CntW'(DATA_W - 1);
                    state_d = StData;
                end
            end
            StData: begin
                if (cnt_q != '0) begin
                    dout_d = pay_q[DATA_W-1];
                    pay_d  = pay_q << 1;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    dout_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                // Corrupted one-hot encoding: fall back to the reset picture.
                state_d = StIdle;
                cnt_d   = '0;
                pre_d   = '0;
                pay_d   = '0;
                dout_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_preamble_serializer.sv
// Bench for preamble_serializer: frame-level output model checked every cycle, plus
// directed literal checks and a small downstream 0xAA detector.
module tb_preamble_serializer;

    localparam logic [7:0] PRE = 8'hAA;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start, dout, busy, done;
    logic [7:0] data;
    logic       start2, dout2, busy2, done2;
    logic [2:0] data2;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    preamble_serializer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    preamble_serializer #(
        .PRE_W    (4),
        .PREAMBLE (4'b1010),
        .DATA_W   (3)
    ) dut_small (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .data  (data2),
        .dout  (dout2),
        .busy  (busy2),
        .done  (done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: a frame is a list of per-cycle {dout, busy, done} values.
    typedef struct packed {
        logic d;
        logic b;
        logic dn;
    } out_t;

    out_t q[$];
    out_t exp_o = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            exp_o <= '0;
        end else begin
            if (q.size() == 0 && start) begin
                for (int i = 0; i < 8; i++) q.push_back({PRE[7-i], 1'b1, 1'b0});
                for (int i = 0; i < 8; i++) q.push_back({data[7-i], 1'b1, 1'b0});
                q.push_back({1'b0, 1'b0, 1'b1});
            end
            if (q.size() != 0) exp_o <= q.pop_front();
            else               exp_o <= '0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("model_dout", dout, exp_o.d);
            check("model_busy", busy, exp_o.b);
            check("model_done", done, exp_o.dn);
        end
    end

    // Downstream Moore detector looking for 8'b1010_1010.
    logic [7:0] win;
    logic       det_flag;
    always @(posedge clk or negedge rst) begin
        if (!rst) win <= '0;
        else      win <= {win[6:0], dout};
    end
    assign det_flag = (win == 8'hAA);

    initial begin
        logic [15:0] t1;
        logic [7:0]  pa;
        logic [6:0]  t6;
        int          dcnt;

        start  = 1'b0;
        data   = '0;
        start2 = 1'b0;
        data2  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        @(negedge clk);

        // Test 1: data 0x3C
        t1    = 16'b1010_1010_0011_1100;
        data  = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("t1_dout", dout, t1[15-k]);
            check("t1_busy", busy, 1);
            @(negedge clk);
        end
        check("t1_done_dout", dout, 0);
        check("t1_done_busy", busy, 0);
        check("t1_done", done, 1);
        @(negedge clk);
        check("t1_done_clear", done, 0);

        // Test 5: idle for 20 cycles
        for (int k = 0; k < 20; k++) begin
            check("t5_idle", {dout, busy, done}, 0);
            @(negedge clk);
        end

        // Test 2: 0xAA payload into the detector
        data  = 8'hAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt  = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 7)  check("t2_det_before", det_flag, 0);
            if (k == 8)  check("t2_det_preamble", det_flag, 1);
            if (k == 16) check("t2_det_payload", det_flag, 1);
            if (done) dcnt++;
            @(negedge clk);
        end
        check("t2_done_pulses", dcnt, 1);

        // Test 3: start held, data changes mid-frame
        pa    = 8'h81;
        data  = 8'h81;
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 35; k++) begin
            if (k == 4)  data  = 8'hFF;
            if (k == 20) start = 1'b0;
            if (k >= 8 && k <= 15) check("t3_payload_a", dout, pa[15-k]);
            if (k == 16) check("t3_gap", {dout, busy, done}, 3'b001);
            if (k == 17) check("t3_b_first", {dout, busy}, 2'b11);
            if (k >= 25 && k <= 32) check("t3_payload_b", dout, 1);
            if (k == 33) check("t3_b_done", done, 1);
            if (k == 34) check("t3_b_idle", busy, 0);
            @(negedge clk);
        end

        // Test 4: asynchronous reset during payload bit 3
        data  = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("t4_pre_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t4_async_rst", {dout, busy, done}, 0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t4_stay_idle", {dout, busy, done}, 0);
        end

        // Test 6: small parameter set
        t6     = 7'b1010110;
        data2  = 3'b110;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("t6_dout", dout2, t6[6-k]);
            check("t6_busy", busy2, 1);
            @(negedge clk);
        end
        check("t6_done", {dout2, busy2, done2}, 3'b001);
        @(negedge clk);
        check("t6_done_clear", done2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
